// File: rtl/risc_pkg.sv
// Shared definitions for the RISC fetch front end.
//   SIZE          instruction / word-address width
//   MEM_SIZE      words in instruction memory (valid addresses 0..MEM_SIZE-1)
//   DEPTH         instruction FIFO entries
//   RESET_PC      first word address fetched after reset
//   fetch_state_e fetch unit FSM states
//   fetch_entry_t one FIFO entry: instruction word plus its word address
package risc_pkg;

  localparam int unsigned SIZE     = 32;
  localparam int unsigned MEM_SIZE = 128;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned RESET_PC = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [SIZE-1:0] instr;
    logic [SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write an entry (accepted when not full, or full with a pop)
//   pop          remove the head (ignored when empty)
//   flush        empty the FIFO; overrides push and pop in the same cycle
//   dout         head entry, read straight from registered storage
//   full, empty  occupancy flags
//   count        number of stored entries
module fetch_fifo
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the pc, addresses the combinational
// instruction memory, queues fetched words and hands them to decode.
//   clka, rsta              clock, asynchronous active-low reset
//   run                     fetch enable (FIFO drains regardless)
//   imem_addr / imem_data   word address out (= pc), instruction word in
//   redirect_valid/_pc      taken branch/jump from execute; flushes the FIFO
//   out_valid/_ready        decode handshake on the FIFO head
//   out_instr, out_pc       head instruction and its word address
//   fetch_fault             sticky: pc ran past the end of memory
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned MEM_SIZE = risc_pkg::MEM_SIZE,
  parameter int unsigned DEPTH    = risc_pkg::DEPTH,
  parameter int unsigned RESET_PC = risc_pkg::RESET_PC
) (
  input  logic            clka,
  input  logic            rsta,
  input  logic            run,
  output logic [SIZE-1:0] imem_addr,
  input  logic [SIZE-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [SIZE-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_instr,
  output logic [SIZE-1:0] out_pc,
  output logic            fetch_fault
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [SIZE-1:0] MEM_LIMIT  = SIZE'(MEM_SIZE);
  localparam logic [SIZE-1:0] RESET_ADDR = SIZE'(RESET_PC);
  localparam logic [CW-1:0]   FILL_LEVEL = CW'(DEPTH - 1);

  fetch_state_e    state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;

  logic            push;
  logic            pop;
  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [SIZE-1:0] next_pc;
  logic            can_fetch;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign imem_addr   = pc_q;
  assign out_valid   = !fifo_empty;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign fetch_fault = fault_q;

  assign pop        = out_valid && out_ready;
  assign next_pc    = pc_q + SIZE'(1);
  assign can_fetch  = run && (pc_q < MEM_LIMIT) && (!fifo_full || pop);
  assign push_entry = '{instr: imem_data, pc: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = (redirect_pc >= MEM_LIMIT) ? FAULT : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (pc_q >= MEM_LIMIT) begin
            state_d = FAULT;
          end else if (can_fetch) begin
            push = 1'b1;
            pc_d = next_pc;
            if (next_pc >= MEM_LIMIT) begin
              state_d = FAULT;
            end else if ((fifo_count == FILL_LEVEL) && !pop) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          // The pop that releases FULL also frees a slot for this cycle's fetch.
          if (pop) begin
            state_d = FETCH;
            if (can_fetch) begin
              push = 1'b1;
              pc_d = next_pc;
              if (next_pc >= MEM_LIMIT) begin
                state_d = FAULT;
              end
            end
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDR;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clka),
    .rst_n (rsta),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int unsigned MEM_WORDS = 128;
  localparam int unsigned FIFO_DEPTH = 2;

  logic        clka;
  logic        rsta;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int unsigned n_assert;
  int unsigned n_fail;

  logic [31:0] imem [MEM_WORDS];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  instr_fetch_unit dut (
    .clka           (clka),
    .rsta           (rsta),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  assign imem_data = (imem_addr < 32'd128) ? imem[imem_addr[6:0]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd128) ? imem[a[6:0]] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'd0;
  endtask

  // One rising edge of the behavioural fetch unit.
  task automatic model_edge();
    int unsigned sz;
    bit          popped;
    ent_t        e;
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
    end else begin
      sz     = mq.size();
      popped = (sz > 0) && out_ready;
      if (popped) void'(mq.pop_front());
      if (run && (m_pc < 32'd128) && ((sz < FIFO_DEPTH) || popped)) begin
        e.instr = mem_word(m_pc);
        e.pc    = m_pc;
        mq.push_back(e);
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    check("fetch_fault", {31'd0, fetch_fault}, (m_pc >= 32'd128) ? 32'd1 : 32'd0);
    if (mq.size() > 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, mq[0].instr);
    end
  endtask

  task automatic step();
    @(posedge clka);
    model_edge();
    @(negedge clka);
    check_all();
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rsta           = 1'b0;
    run            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) imem[i] = $urandom;
    model_reset();

    // Reset values
    repeat (2) @(negedge clka);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // Streaming from reset release
    rsta = 1'b1;
    step();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'd0);
    check("first_instr", out_instr, imem[0]);
    repeat (6) step();

    // Back-pressure fills the FIFO and stalls the pc
    redirect(32'd0);
    check("stall_redir_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("stall_head0", out_pc, 32'd0);
    out_ready = 1'b0;
    repeat (5) step();
    check("stall_addr", imem_addr, 32'd2);
    check("stall_head", out_pc, 32'd0);
    out_ready = 1'b1;
    step();
    check("resume_pc1", out_pc, 32'd1);
    step();
    check("resume_pc2", out_pc, 32'd2);

    // Redirect with a full FIFO at pc 14
    redirect(32'd12);
    out_ready = 1'b0;
    repeat (3) step();
    check("full14_addr", imem_addr, 32'd14);
    check("full14_head", out_pc, 32'd12);
    out_ready = 1'b1;
    redirect(32'd20);
    check("redir20_valid", {31'd0, out_valid}, 32'd0);
    check("redir20_addr", imem_addr, 32'd20);
    step();
    check("redir20_pc", out_pc, 32'd20);
    check("redir20_instr", out_instr, imem[20]);

    // Redirect coinciding with a pop at count 1
    redirect(32'd30);
    step();
    check("cnt1_head", out_pc, 32'd30);
    redirect(32'd40);
    check("poprd_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("poprd_pc", out_pc, 32'd40);

    // Running off the end of memory
    out_ready = 1'b0;
    redirect(32'd126);
    step();
    step();
    check("end_fault", {31'd0, fetch_fault}, 32'd1);
    check("end_addr", imem_addr, 32'd128);
    check("end_head", out_pc, 32'd126);
    out_ready = 1'b1;
    step();
    check("drain_127", out_pc, 32'd127);
    step();
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    step();
    check("fault_nopush", {31'd0, out_valid}, 32'd0);
    check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    redirect(32'd0);
    check("fault_clear", {31'd0, fetch_fault}, 32'd0);
    step();
    check("fault_resume", out_pc, 32'd0);

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rsta = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_addr", imem_addr, 32'd0);
    model_reset();
    @(posedge clka);
    @(negedge clka);
    rsta      = 1'b1;
    out_ready = 1'b1;
    step();
    check("restart_pc0", out_pc, 32'd0);
    step();
    check("restart_pc1", out_pc, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      run            = (($urandom % 8) != 0);
      out_ready      = (($urandom % 3) != 0);
      redirect_valid = (($urandom % 16) == 0);
      redirect_pc    = (($urandom % 2) == 0) ? 32'($urandom_range(127, 118))
                                             : 32'($urandom_range(127, 0));
      step();
    end
    redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
